approx_mult_seq: RTL and testbench

- Parametrised, sequential successor to the fixed 8x8 quadrant-based approximate multipliers.
- Splits WIDTH x WIDTH operands into 4-bit digits and computes all D*D digit products on one shared 4x4 unit, one product per cycle.
- Each product is exact or truncated, selected by its weight. Products are combined by exact addition or, optionally, by OR-combining the low-weight products.
- Sits in the approximate-multiplier library as a low-area, run-time-configurable option with valid/ready handshakes on both sides.

---
 rtl/approx_mult_pkg.sv | 17 +
 rtl/approx_mult_seq_mul4.sv | 21 ++
 rtl/approx_mult_seq.sv | 144 ++++++++++++++
 tb/tb_approx_mult_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the sequential digit-serial approximate multiplier.
package approx_mult_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Number of 4-bit digits in an operand of the given width.
    function automatic int digit_count(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/approx_mult_seq_mul4.sv
// Shared 4x4 digit multiplier; optionally clears the low TRUNC bits of the product.
module approx_mul4 #(
    parameter int TRUNC = 2
) (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       trunc_en,
    output logic [7:0] p
);

    localparam logic [7:0] KEEP_MASK = 8'hFF << TRUNC;

    logic [7:0] prod;

    // Exact 8-bit product, then masked when truncation is requested.
    always_comb begin
        prod = {4'b0000, x} * {4'b0000, y};
        p    = trunc_en ? (prod & KEEP_MASK) : prod;
    end

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential approximate multiplier: one digit product per cycle on a shared 4x4 unit,
// low-weight products optionally truncated and/or OR-combined.
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int APPROX_K = 1,
    parameter int TRUNC    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx_en,
    input  logic               or_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int D  = digit_count(WIDTH);
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int KW = CW + 1;
    localparam int RW = 2 * WIDTH;

    state_t          state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic            approx_en_reg, or_mode_reg;
    logic [CW-1:0]   i_reg, j_reg;
    logic            pairs_done_reg;
    logic [RW-1:0]   or_acc_reg, add_acc_reg, r_reg;

    logic [DIGIT_W-1:0] a_digs [D];
    logic [DIGIT_W-1:0] b_digs [D];
    logic [KW-1:0]      k;
    logic               low_weight;
    logic [7:0]         p;
    logic [RW-1:0]      s;

    // Split the latched operands into digits so the counters can select them directly.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_digits
            assign a_digs[gi] = a_reg[gi*DIGIT_W +: DIGIT_W];
            assign b_digs[gi] = b_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // Weight of the current pair and its shifted contribution.
    always_comb begin
        k          = {1'b0, i_reg} + {1'b0, j_reg};
        low_weight = (k < KW'(APPROX_K));
        s          = RW'(p) << {k, 2'b00};
    end

    approx_mul4 #(
        .TRUNC(TRUNC)
    ) u_mul4 (
        .x       (a_digs[i_reg]),
        .y       (b_digs[j_reg]),
        .trunc_en(approx_en_reg & low_weight),
        .p       (p)
    );

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (pairs_done_reg) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign r = r_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Datapath: operand capture, digit walk, accumulation and the final sum.
    // The final add gets its own cycle so it never sits behind the accumulate path.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg          <= '0;
            b_reg          <= '0;
            approx_en_reg  <= 1'b0;
            or_mode_reg    <= 1'b0;
            i_reg          <= '0;
            j_reg          <= '0;
            pairs_done_reg <= 1'b0;
            or_acc_reg     <= '0;
            add_acc_reg    <= '0;
            r_reg          <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg          <= a;
                        b_reg          <= b;
                        approx_en_reg  <= approx_en;
                        or_mode_reg    <= or_mode;
                        i_reg          <= '0;
                        j_reg          <= '0;
                        pairs_done_reg <= 1'b0;
                        or_acc_reg     <= '0;
                        add_acc_reg    <= '0;
                    end
                end
                CALC: begin
                    if (!pairs_done_reg) begin
                        if (or_mode_reg && low_weight) or_acc_reg  <= or_acc_reg | s;
                        else                           add_acc_reg <= add_acc_reg + s;
                        if (i_reg == CW'(D - 1)) begin
                            i_reg <= '0;
                            if (j_reg == CW'(D - 1)) pairs_done_reg <= 1'b1;
                            else                     j_reg <= j_reg + CW'(1);
                        end else begin
                            i_reg <= i_reg + CW'(1);
                        end
                    end else begin
                        r_reg <= or_acc_reg + add_acc_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Self-checking bench: three instances (8-bit K=1, 8-bit K=2, 16-bit K=3 T=3) driven
// by directed and random operations, checked against an arithmetic reference model.
module tb_approx_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid_v = 3'b000;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        approx_en = 1'b0;
    logic        or_mode = 1'b0;
    logic [15:0] r0, r1;
    logic [31:0] r2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    approx_mult_seq #(.WIDTH(8), .APPROX_K(1), .TRUNC(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a[7:0]), .b(b[7:0]), .approx_en(approx_en), .or_mode(or_mode),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .r(r0));

    approx_mult_seq #(.WIDTH(8), .APPROX_K(2), .TRUNC(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a[7:0]), .b(b[7:0]), .approx_en(approx_en), .or_mode(or_mode),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .r(r1));

    approx_mult_seq #(.WIDTH(16), .APPROX_K(3), .TRUNC(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .approx_en(approx_en), .or_mode(or_mode),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .r(r2));

    function automatic logic [31:0] get_r(input int idx);
        case (idx)
            0:       return {16'h0, r0};
            1:       return {16'h0, r1};
            default: return r2;
        endcase
    endfunction

    function automatic int width_of(input int idx);
        return (idx == 2) ? 16 : 8;
    endfunction

    function automatic int k_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int trunc_of(input int idx);
        return (idx == 2) ? 3 : 2;
    endfunction

    // Reference: sum of digit products by weight, truncated / OR-combined by rule.
    function automatic logic [31:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                          input bit ae, input bit om, input int idx);
        int          d;
        int          p;
        logic [31:0] orv, addv, s;
        d    = width_of(idx) / 4;
        orv  = 0;
        addv = 0;
        for (int j = 0; j < d; j++) begin
            for (int i = 0; i < d; i++) begin
                p = int'((aa >> (4 * i)) & 16'hF) * int'((bb >> (4 * j)) & 16'hF);
                if (ae && (i + j) < k_of(idx)) p = p & ~((1 << trunc_of(idx)) - 1);
                s = 32'(p) << (4 * (i + j));
                if (om && (i + j) < k_of(idx)) orv = orv | s;
                else                           addv = addv + s;
            end
        end
        if (width_of(idx) == 8) return (orv + addv) & 32'hFFFF;
        return orv + addv;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation on instance idx, with optional backpressure of 'hold' cycles.
    task automatic run_op(input int idx, input logic [15:0] aa, input logic [15:0] bb,
                          input bit ae, input bit om, input logic [31:0] exp, input int hold);
        int          cyc;
        bit          busy_ok;
        logic [31:0] r_first;
        cyc = 0;
        @(posedge clk); #1;
        while (!in_ready_v[idx] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_idle", {31'h0, in_ready_v[idx]}, 32'h1);
        a = aa; b = bb; approx_en = ae; or_mode = om;
        in_valid_v[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[idx] = 1'b0;
        a = ~aa; b = ~bb; approx_en = ~ae; or_mode = ~om;
        cyc = 0;
        busy_ok = 1'b1;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (in_ready_v[idx]) busy_ok = 1'b0;
            if (out_valid_v[idx]) break;
        end
        chk("latency", 32'(cyc), 32'(((width_of(idx) / 4) ** 2) + 1));
        chk("in_ready_busy", {31'h0, busy_ok}, 32'h1);
        chk("result", get_r(idx), exp);
        $display("op dut%0d a=%h b=%h ae=%0d om=%0d r=%h exp=%h lat=%0d",
                 idx, aa, bb, ae, om, get_r(idx), exp, cyc);
        r_first = get_r(idx);
        busy_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (h == 3) begin
                a = 16'h5A5A; b = 16'hA5A5;
                in_valid_v[idx] = 1'b1;
            end else begin
                in_valid_v[idx] = 1'b0;
            end
            @(posedge clk); #1;
            if (get_r(idx) !== r_first || !out_valid_v[idx] || in_ready_v[idx]) busy_ok = 1'b0;
        end
        in_valid_v[idx] = 1'b0;
        if (hold > 0) chk("backpressure_hold", {31'h0, busy_ok}, 32'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", {31'h0, out_valid_v[idx]}, 32'h0);
        chk("release_in_ready", {31'h0, in_ready_v[idx]}, 32'h1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        bit          rae, rom;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", {29'h0, in_ready_v}, 32'h7);
        chk("reset_out_valid", {29'h0, out_valid_v}, 32'h0);
        chk("reset_r0", {16'h0, r0}, 32'h0);
        chk("reset_r2", r2, 32'h0);

        // Directed cases on the 8-bit instances.
        run_op(0, 16'hFF, 16'hFF, 1'b0, 1'b0, 32'hFE01, 0);
        run_op(0, 16'hFF, 16'hFF, 1'b1, 1'b0, 32'hFE00, 0);
        run_op(1, 16'hFF, 16'hFF, 1'b1, 1'b0, 32'hFDE0, 0);
        run_op(1, 16'hFF, 16'hFF, 1'b1, 1'b1, 32'hEFE0, 10);
        run_op(1, 16'hFF, 16'hFF, 1'b0, 1'b1, model(16'hFF, 16'hFF, 1'b0, 1'b1, 1), 0);

        // Reset two cycles into CALC aborts the operation.
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h00FF; approx_en = 1'b0; or_mode = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {31'h0, out_valid_v[0]}, 32'h0);
        chk("abort_r", {16'h0, r0}, 32'h0);
        chk("abort_in_ready", {31'h0, in_ready_v[0]}, 32'h1);
        $display("op dut0 reset during CALC");
        run_op(0, 16'h12, 16'h34, 1'b0, 1'b0, 32'h03A8, 0);

        // Random mixed-mode operations on the 8-bit instances.
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rae = 1'($urandom);
            rom = 1'($urandom);
            run_op(n % 2, ra, rb, rae, rom, model(ra, rb, rae, rom, n % 2), 0);
        end

        // 16-bit exact mode: corner plus random operands against a*b.
        run_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 0);
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(2, ra, rb, 1'b0, 1'b0, 32'(ra) * 32'(rb), 0);
        end

        // 16-bit approximate modes against the reference model.
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rae = 1'($urandom);
            rom = 1'($urandom);
            run_op(2, ra, rb, rae, rom, model(ra, rb, rae, rom, 2), (n == 0) ? 10 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
